// File: rtl/ram_arbiter_if.sv
// Bundles the requester handshakes and the RAM port of ram_arbiter.
//   slave  : arbiter side (takes requests, drives ACK/RDATA/BUSY and the RAM controls)
//   master : environment side (two requesters plus the RAM read path)
// Signals: req/we/addr/wdata per requester in; ack/rdata per requester out;
//          busy; ram_address/ram_data_in/ram_opcode out; ram_data_out in.
interface ram_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          req_0;
  logic          req_1;
  logic          we_0;
  logic          we_1;
  logic [AW-1:0] addr_0;
  logic [AW-1:0] addr_1;
  logic [DW-1:0] wdata_0;
  logic [DW-1:0] wdata_1;
  logic          ack_0;
  logic          ack_1;
  logic [DW-1:0] rdata_0;
  logic [DW-1:0] rdata_1;
  logic          busy;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_opcode;
  logic [DW-1:0] ram_data_out;

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, ram_data_out,
    output ack_0, ack_1, rdata_0, rdata_1, busy, ram_address, ram_data_in, ram_opcode
  );

  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, ram_data_out,
    input  ack_0, ack_1, rdata_0, rdata_1, busy, ram_address, ram_data_in, ram_opcode
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register RAM.
// Each transaction takes IDLE -> ACCESS -> DONE (one cycle each); the winner's
// ACK pulses in DONE and read data is captured at the ACCESS->DONE edge.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave (requester handshakes and RAM port)
// All outputs are registered.
module ram_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input logic           clk,
  input logic           rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e        state_q;
  logic          winner_q;   // requester of the transaction in flight
  logic          last_q;     // requester served most recently
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          opcode_q;
  logic          busy_q;
  logic          ack_0_q;
  logic          ack_1_q;
  logic [DW-1:0] rdata_0_q;
  logic [DW-1:0] rdata_1_q;

  logic          grant_1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    grant_1   = bus.req_1 && (!bus.req_0 || !last_q);
    sel_we    = grant_1 ? bus.we_1    : bus.we_0;
    sel_addr  = grant_1 ? bus.addr_1  : bus.addr_0;
    sel_wdata = grant_1 ? bus.wdata_1 : bus.wdata_0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      winner_q  <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      opcode_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_0_q   <= 1'b0;
      ack_1_q   <= 1'b0;
      rdata_0_q <= '0;
      rdata_1_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_0 || bus.req_1) begin
            winner_q <= grant_1;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            opcode_q <= sel_we;
            busy_q   <= 1'b1;
            state_q  <= StAccess;
          end
        end
        StAccess: begin
          opcode_q <= 1'b0;
          if (!we_q) begin
            if (winner_q) rdata_1_q <= bus.ram_data_out;
            else          rdata_0_q <= bus.ram_data_out;
          end
          ack_0_q <= !winner_q;
          ack_1_q <= winner_q;
          state_q <= StDone;
        end
        StDone: begin
          ack_0_q <= 1'b0;
          ack_1_q <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= winner_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack_0       = ack_0_q;
  assign bus.ack_1       = ack_1_q;
  assign bus.rdata_0     = rdata_0_q;
  assign bus.rdata_1     = rdata_1_q;
  assign bus.busy        = busy_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = wdata_q;
  assign bus.ram_opcode  = opcode_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed stimulus, a transaction-level model compared
// every cycle, and literal expectations for the scenarios of interest.
module tb_ram_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  ram_arbiter_if #(.AW(4), .DW(8)) bus ();

  ram_arbiter #(.AW(4), .DW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: combinational read, write on rising edge when opcode = 1.
  logic [7:0] ram [16];
  assign bus.ram_data_out = ram[bus.ram_address];
  always @(posedge clk) begin
    if (bus.ram_opcode) ram[bus.ram_address] <= bus.ram_data_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: age counts cycles since the grant (0 = no transaction).
  int         age;
  logic       m_who;
  logic       m_last;
  logic       m_we;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rd0;
  logic [7:0] m_rd1;
  logic [7:0] m_mem [16];
  int         grants[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age     <= 0;
      m_last  <= 1'b1;
      m_who   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rd0   <= '0;
      m_rd1   <= '0;
    end else if (age == 0) begin
      if (bus.req_0 || bus.req_1) begin
        logic w;
        w = (bus.req_0 && bus.req_1) ? !m_last : bus.req_1;
        m_who   <= w;
        m_we    <= w ? bus.we_1 : bus.we_0;
        m_addr  <= w ? bus.addr_1 : bus.addr_0;
        m_wdata <= w ? bus.wdata_1 : bus.wdata_0;
        grants.push_back(int'(w));
        age <= 1;
      end
    end else if (age == 1) begin
      if (m_we) m_mem[m_addr] <= m_wdata;
      else if (m_who) m_rd1 <= m_mem[m_addr];
      else m_rd0 <= m_mem[m_addr];
      age <= 2;
    end else begin
      m_last <= m_who;
      age    <= 0;
    end
  end

  // Observed ACK order and timing.
  int ack_who[$];
  int ack_t[$];

  always @(negedge clk) begin
    cyc++;
    chk("busy",     32'(bus.busy),        32'(age != 0));
    chk("opcode",   32'(bus.ram_opcode),  32'(age == 1 && m_we));
    chk("ack_0",    32'(bus.ack_0),       32'(age == 2 && !m_who));
    chk("ack_1",    32'(bus.ack_1),       32'(age == 2 && m_who));
    chk("ack_excl", 32'(bus.ack_0 & bus.ack_1), 32'd0);
    chk("ram_addr", 32'(bus.ram_address), 32'(m_addr));
    chk("ram_din",  32'(bus.ram_data_in), 32'(m_wdata));
    chk("rdata_0",  32'(bus.rdata_0),     32'(m_rd0));
    chk("rdata_1",  32'(bus.rdata_1),     32'(m_rd1));
    if (bus.ack_0) begin ack_who.push_back(0); ack_t.push_back(cyc); end
    if (bus.ack_1) begin ack_who.push_back(1); ack_t.push_back(cyc); end
  end

  task automatic idle_inputs();
    bus.req_0 = 0; bus.req_1 = 0; bus.we_0 = 0; bus.we_1 = 0;
    bus.addr_0 = 0; bus.addr_1 = 0; bus.wdata_0 = 0; bus.wdata_1 = 0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      ram[i]   = 8'h10 + 8'(i);
      m_mem[i] = 8'h10 + 8'(i);
    end
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(bus.busy),        0);
    chk("rst_opcode", 32'(bus.ram_opcode),  0);
    chk("rst_addr",   32'(bus.ram_address), 0);
    chk("rst_rdata0", 32'(bus.rdata_0),     0);

    // Both requesting from reset: alternating reads of addr 0 / addr 1.
    bus.req_0 = 1; bus.req_1 = 1; bus.addr_0 = 4'h0; bus.addr_1 = 4'h1;
    ack_who.delete(); ack_t.delete(); grants.delete();
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1 idle_inputs();
    repeat (2) @(negedge clk);
    chk("rr_nacks", 32'(ack_who.size()), 4);
    if (ack_who.size() >= 4) begin
      chk("rr_g0", 32'(ack_who[0]), 0);
      chk("rr_g1", 32'(ack_who[1]), 1);
      chk("rr_g2", 32'(ack_who[2]), 0);
      chk("rr_g3", 32'(ack_who[3]), 1);
      chk("rr_gap1", 32'(ack_t[1] - ack_t[0]), 3);
      chk("rr_gap2", 32'(ack_t[2] - ack_t[1]), 3);
      chk("rr_model_g1", 32'(grants[1]), 1);
    end
    chk("rr_rd0", 32'(bus.rdata_0), 32'h10);
    chk("rr_rd1", 32'(bus.rdata_1), 32'h11);

    // Requester 0 writes A5 to address 3.
    #1 bus.req_0 = 1; bus.we_0 = 1; bus.addr_0 = 4'h3; bus.wdata_0 = 8'hA5;
    @(negedge clk);
    chk("wr_opcode", 32'(bus.ram_opcode),  1);
    chk("wr_addr",   32'(bus.ram_address), 3);
    #1 idle_inputs();
    @(negedge clk);
    chk("wr_ack0",   32'(bus.ack_0),      1);
    chk("wr_opc_dn", 32'(bus.ram_opcode), 0);
    chk("wr_rd0",    32'(bus.rdata_0),    32'h10);
    repeat (2) @(negedge clk);

    // Requester 1 reads address 3 back.
    #1 bus.req_1 = 1; bus.we_1 = 0; bus.addr_1 = 4'h3;
    @(negedge clk);
    chk("rd_opcode", 32'(bus.ram_opcode), 0);
    #1 idle_inputs();
    @(negedge clk);
    chk("rd_ack1", 32'(bus.ack_1),   1);
    chk("rd_rd1",  32'(bus.rdata_1), 32'hA5);
    repeat (2) @(negedge clk);

    // Requester 0 read of address 5, address and request change during ACCESS.
    #1 bus.req_0 = 1; bus.we_0 = 0; bus.addr_0 = 4'h5;
    @(negedge clk);
    chk("chg_addr_acc", 32'(bus.ram_address), 5);
    #1 bus.addr_0 = 4'hF; bus.req_0 = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("chg_addr_dn", 32'(bus.ram_address), 5);
      if (bus.ack_0) n++;
    end
    chk("chg_ack_once", 32'(n), 1);
    chk("chg_rd0", 32'(bus.rdata_0), 32'h15);

    // Reset during ACCESS of a write from requester 1.
    #1 bus.req_1 = 1; bus.we_1 = 1; bus.addr_1 = 4'h7; bus.wdata_1 = 8'h3C;
    @(negedge clk);
    chk("abort_opc_pre", 32'(bus.ram_opcode), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy),        0);
    chk("abort_opc",  32'(bus.ram_opcode),  0);
    chk("abort_ack1", 32'(bus.ack_1),       0);
    chk("abort_addr", 32'(bus.ram_address), 0);
    @(negedge clk);
    chk("abort_noack", 32'(bus.ack_1), 0);
    chk("abort_ram7", 32'(ram[7]), 32'h17);
    bus.req_0 = 1; bus.we_0 = 0; bus.addr_0 = 4'h2;
    bus.req_1 = 1; bus.we_1 = 0; bus.addr_1 = 4'h4;
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ack0", 32'(bus.ack_0),   1);
    chk("post_rst_ack1", 32'(bus.ack_1),   0);
    chk("post_rst_rd0",  32'(bus.rdata_0), 32'h12);
    #1 idle_inputs();
    repeat (2) @(negedge clk);

    // Twenty quiet cycles.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy || bus.ram_opcode || bus.ack_0 || bus.ack_1) n++;
    end
    chk("quiet", 32'(n), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
